// File: rtl/ripple_counter_controller.sv
// Run controller for the team's 8-bit ripple counter: it paces tick pulses through a
// prescaler, clears the chain at each run start and tracks the count in a shadow register.
`timescale 1ns/1ps
module ripple_counter_controller (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       pause_i,
  input  logic       reload_mode_i,
  input  logic [7:0] terminal_i,
  input  logic [7:0] prescale_i,
  output logic       tick_o,
  output logic       toggle_o,
  output logic       counter_clear_n_o,
  output logic [7:0] shadow_count_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PAUSED = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] term_q, term_d;
  logic [7:0] presc_cfg_q, presc_cfg_d;
  logic       reload_q, reload_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] count_q, count_d;
  logic       tick_q, tick_d;
  logic       done_q, done_d;

  logic [7:0] eff_presc;
  logic       terminal_hit;

  // A zero prescale would let tick stay high back to back, so it is bumped to 1.
  assign eff_presc    = (presc_cfg_q == 8'd0) ? 8'd1 : presc_cfg_q;
  assign terminal_hit = tick_q && (count_q == term_q);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d     = state_q;
    term_d      = term_q;
    presc_cfg_d = presc_cfg_q;
    reload_d    = reload_q;
    presc_d     = presc_q;
    count_d     = count_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          term_d      = terminal_i;
          presc_cfg_d = prescale_i;
          reload_d    = reload_mode_i;
          count_d     = 8'd0;
          presc_d     = 8'd0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (stop_i)       state_d = S_IDLE;
        else if (pause_i) state_d = S_PAUSED;
        else              state_d = S_RUN;
      end
      S_RUN: begin
        // Priority: stop, then completion of the terminal tick, then pause, then counting.
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (terminal_hit) begin
          done_d = 1'b1;
          if (reload_q) begin
            count_d = 8'd0;
            presc_d = 8'd0;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end else if (pause_i) begin
          state_d = S_PAUSED;
        end else if (presc_q == eff_presc) begin
          tick_d  = 1'b1;
          count_d = count_q + 8'd1;
          presc_d = 8'd0;
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      S_PAUSED: begin
        if (stop_i)        state_d = S_IDLE;
        else if (!pause_i) state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      term_q      <= 8'd0;
      presc_cfg_q <= 8'd0;
      reload_q    <= 1'b0;
      presc_q     <= 8'd0;
      count_q     <= 8'd0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      term_q      <= term_d;
      presc_cfg_q <= presc_cfg_d;
      reload_q    <= reload_d;
      presc_q     <= presc_d;
      count_q     <= count_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  assign tick_o            = tick_q;
  assign done_o            = done_q;
  assign shadow_count_o    = count_q;
  assign busy_o            = (state_q != S_IDLE);
  assign counter_clear_n_o = (state_q != S_CLEAR);
  assign toggle_o          = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_PAUSED);

endmodule

// File: doc/ripple_counter_controller.md
RIPPLE_COUNTER_CONTROLLER -- requirements
Module: ripple_counter_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8 bits, matching the team's 8-bit ripple counter.
REQ-002 clock  input  1  Single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset.
REQ-004 start  input  1  Single-cycle command; begins a count run when idle.
REQ-005 stop  input  1  Single-cycle command; aborts a run.
REQ-006 pause  input  1  Level input; high holds a run.
REQ-007 reload_mode  input  1  0 = one-shot, 1 = auto-reload.
REQ-008 terminal  input  8  Tick count per run; 0 means 256.
REQ-009 prescale  input  8  Clock cycles between ticks, minus 1; 0 is treated as 1.
REQ-010 tick  output  1  Registered one-cycle pulse; drives the clock input of the counter chain.
REQ-011 toggle  output  1  Toggle enable to the counter; high in CLEAR, RUN and PAUSED.
REQ-012 counter_clear_n  output  1  Active-low clear to the counter; low for exactly one cycle per run start.
REQ-013 shadow_count  output  8  Internal mirror of the counter value.
REQ-014 busy  output  1  High in every state except IDLE.
REQ-015 done  output  1  Registered one-cycle pulse on run completion.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, RUN, PAUSED and DONE.
REQ-017 In IDLE, start SHALL latch terminal, prescale and reload_mode into shadow registers and transition to CLEAR on the next edge.
REQ-018 Input changes on terminal, prescale or reload_mode during a run SHALL have no effect until the next latch.
REQ-019 CLEAR SHALL last one cycle, with counter_clear_n=0, shadow_count set to 0 and the prescaler set to 0, then transition to RUN.
REQ-020 In RUN, the prescaler SHALL increment each cycle; when it equals the effective prescale, the next cycle SHALL have tick=1, shadow_count incremented modulo 256 and the prescaler reset to 0.
REQ-021 The tick period SHALL be effective_prescale+1 cycles (minimum 2), so tick is never high on two consecutive cycles.
REQ-022 The terminal tick SHALL be the tick on which shadow_count becomes terminal (mod 256); terminal=0 therefore completes after 256 ticks, with shadow_count wrapped to 0.
REQ-023 After the terminal tick, a one-shot run SHALL go to DONE and an auto-reload run SHALL go to CLEAR; done=1 in the cycle after the terminal tick in both modes.
REQ-024 DONE SHALL last one cycle, then transition to IDLE; shadow_count holds its final value in IDLE.
REQ-025 In RUN, pause=1 SHALL transition to PAUSED; in PAUSED the prescaler and shadow_count freeze and tick=0.
REQ-026 pause=0 in PAUSED SHALL resume RUN from the frozen prescaler value.
REQ-027 stop in CLEAR, RUN or PAUSED SHALL transition to IDLE on the next edge: no done, no further tick, shadow_count frozen.
REQ-028 Priority SHALL be stop > terminal completion > pause.
REQ-029 stop in the same cycle that the terminal tick is scheduled SHALL suppress both that tick and done.
REQ-030 start while busy=1 SHALL be ignored; start together with stop in IDLE SHALL be ignored.
REQ-031 Simultaneous start and pause in IDLE SHALL enter CLEAR, then PAUSED if pause is still high.

Reset
REQ-032 Asserting reset=0 SHALL force, asynchronously, state=IDLE, tick=0, toggle=0, counter_clear_n=1, shadow_count=0, busy=0, done=0, and all shadow registers and the prescaler to 0.
REQ-033 Reset asserted mid-run SHALL take effect immediately, without waiting for a clock edge, and without issuing done.
REQ-034 After reset deassertion, the block SHALL accept start on the first rising edge.

Verification
REQ-035 One-shot: terminal=5, prescale=2, start -> counter_clear_n low 1 cycle; 5 ticks spaced 3 cycles apart; shadow_count reaches 5; done pulses once; busy drops after DONE.
REQ-036 Auto-reload: terminal=3, prescale=0, reload_mode=1 -> tick every 2 cycles; done pulse and counter_clear_n low pulse every 3 ticks; stop -> IDLE with no done.
REQ-037 Wrap: terminal=0, prescale=1 -> exactly 256 ticks; shadow_count wraps 255 -> 0; done asserted once.
REQ-038 Pause: terminal=4, pause high for 10 cycles after tick 2 -> no ticks, shadow_count held at 2; resume completes with exactly 2 more ticks.
REQ-039 Reset mid-run: reset low asynchronously between edges at shadow_count=3 -> all outputs take reset values immediately; no done.
REQ-040 Corner: start while busy is ignored and the run is unchanged; stop on the terminal-tick cycle yields no tick, no done, shadow_count = terminal-1.
